// File: rtl/memory_writeback_stage.sv
// -----------------------------------------------------------------------------
// memory_writeback_stage
//
// Writeback pipeline stage built as a two-entry skid buffer (head + skid).
// Each accepted entry picks its writeback value (memory load data or ALU
// result) and records the destination register, write enable and
// next-instruction flag. Entries leave in acceptance order.
//
// Parameters:
//   DATA_W  writeback data width (default 16)
//   REG_AW  destination register address width (default 4)
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-high reset
//   flush          discard all held entries (and the entry offered this cycle)
//   in_valid       upstream entry present
//   in_ready       stage can accept (registered)
//   in_wbs         writeback select: 1 = in_mem_data, 0 = in_calc_data
//   in_mem_data    memory load data
//   in_calc_data   ALU result
//   in_ni          next-instruction flag
//   in_rd          destination register
//   in_we          register write enable
//   out_valid      head entry present
//   out_ready      register file accepts head entry
//   out_wb_data    head writeback data (holds last value while idle)
//   out_rd         head destination register (holds last value while idle)
//   out_we         head write enable, gated by out_valid
//   out_ni         head next-instruction flag (holds last value while idle)
//
// Optional feature (macro MEMORY_WRITEBACK_FORWARD_EN):
//   fwd_valid      out_valid && head write enable
//   fwd_rd         head destination register
//   fwd_data       head writeback data
// -----------------------------------------------------------------------------
module memory_writeback_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wbs,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_calc_data,
  input  logic              in_ni,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_wb_data,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_we,
  output logic              out_ni
`ifdef MEMORY_WRITEBACK_FORWARD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t state;

  logic              valid_q;
  logic              ready_q;

  logic [DATA_W-1:0] head_data;
  logic [REG_AW-1:0] head_rd;
  logic              head_we;
  logic              head_ni;

  logic [DATA_W-1:0] skid_data;
  logic [REG_AW-1:0] skid_rd;
  logic              skid_we;
  logic              skid_ni;

  logic              accept;
  logic              release_head;
  logic [DATA_W-1:0] cap_data;
  logic              cap_we;

  always_comb begin
    accept       = in_valid && ready_q;
    release_head = valid_q && out_ready;
    cap_data     = in_wbs ? in_mem_data : in_calc_data;
    // Register 0 is never written, so its enable is dropped at capture.
    cap_we       = in_we && (in_rd != '0);
  end

  // Head fields are only overwritten when a new entry becomes head, so they
  // keep their last value after the stage drains or is flushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      head_data <= '0;
      head_rd   <= '0;
      head_we   <= 1'b0;
      head_ni   <= 1'b0;
      skid_data <= '0;
      skid_rd   <= '0;
      skid_we   <= 1'b0;
      skid_ni   <= 1'b0;
    end else if (flush) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            head_data <= cap_data;
            head_rd   <= in_rd;
            head_we   <= cap_we;
            head_ni   <= in_ni;
            valid_q   <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          case ({accept, release_head})
            2'b11: begin
              head_data <= cap_data;
              head_rd   <= in_rd;
              head_we   <= cap_we;
              head_ni   <= in_ni;
            end
            2'b10: begin
              skid_data <= cap_data;
              skid_rd   <= in_rd;
              skid_we   <= cap_we;
              skid_ni   <= in_ni;
              ready_q   <= 1'b0;
              state     <= TWO;
            end
            2'b01: begin
              valid_q <= 1'b0;
              state   <= EMPTY;
            end
            default: ;
          endcase
        end
        TWO: begin
          // in_ready is low here, so release is the only possible event.
          if (release_head) begin
            head_data <= skid_data;
            head_rd   <= skid_rd;
            head_we   <= skid_we;
            head_ni   <= skid_ni;
            ready_q   <= 1'b1;
            state     <= ONE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= EMPTY;
        end
      endcase
    end
  end

  always_comb begin
    in_ready    = ready_q;
    out_valid   = valid_q;
    out_wb_data = head_data;
    out_rd      = head_rd;
    out_ni      = head_ni;
    out_we      = valid_q && head_we;
  end

`ifdef MEMORY_WRITEBACK_FORWARD_EN
  always_comb begin
    fwd_valid = valid_q && head_we;
    fwd_rd    = head_rd;
    fwd_data  = head_data;
  end
`endif

endmodule

// File: tb/tb_memory_writeback_stage.sv
module tb_memory_writeback_stage;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          in_wbs;
  logic [DW-1:0] in_mem_data;
  logic [DW-1:0] in_calc_data;
  logic          in_ni;
  logic [AW-1:0] in_rd;
  logic          in_we;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_wb_data;
  logic [AW-1:0] out_rd;
  logic          out_we;
  logic          out_ni;
`ifdef MEMORY_WRITEBACK_FORWARD_EN
  logic          fwd_valid;
  logic [AW-1:0] fwd_rd;
  logic [DW-1:0] fwd_data;
`endif

  memory_writeback_stage #(
    .DATA_W(DW),
    .REG_AW(AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_wbs      (in_wbs),
    .in_mem_data (in_mem_data),
    .in_calc_data(in_calc_data),
    .in_ni       (in_ni),
    .in_rd       (in_rd),
    .in_we       (in_we),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_wb_data (out_wb_data),
    .out_rd      (out_rd),
    .out_we      (out_we),
    .out_ni      (out_ni)
`ifdef MEMORY_WRITEBACK_FORWARD_EN
    ,
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] rd;
    logic          we;
    logic          ni;
  } entry_t;

  entry_t        q[$];
  logic [DW-1:0] last_data;
  logic [AW-1:0] last_rd;
  logic          last_ni;
  int            checks;
  int            errors;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic wbs, input logic [DW-1:0] mem,
                       input logic [DW-1:0] calc, input logic [AW-1:0] rd,
                       input logic we, input logic ni);
    in_valid     = v;
    in_wbs       = wbs;
    in_mem_data  = mem;
    in_calc_data = calc;
    in_rd        = rd;
    in_we        = we;
    in_ni        = ni;
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_we", {31'd0, out_we}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_wb_data", {16'd0, out_wb_data}, 32'd0);
    chk("rst_out_rd", {28'd0, out_rd}, 32'd0);
    chk("rst_out_ni", {31'd0, out_ni}, 32'd0);
`ifdef MEMORY_WRITEBACK_FORWARD_EN
    chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
`endif
  endtask

  // Checks the DUT against the scoreboard for the current cycle, then
  // advances the scoreboard by what the current inputs will do at the edge.
  task automatic cycle();
    entry_t e;
    logic   acc;
    logic   rel;
    chk("in_ready", {31'd0, in_ready}, (q.size() < 2) ? 32'd1 : 32'd0);
    chk("out_valid", {31'd0, out_valid}, (q.size() > 0) ? 32'd1 : 32'd0);
    if (q.size() > 0) begin
      chk("out_wb_data", {16'd0, out_wb_data}, {16'd0, q[0].data});
      chk("out_rd", {28'd0, out_rd}, {28'd0, q[0].rd});
      chk("out_we", {31'd0, out_we}, {31'd0, q[0].we});
      chk("out_ni", {31'd0, out_ni}, {31'd0, q[0].ni});
`ifdef MEMORY_WRITEBACK_FORWARD_EN
      chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, q[0].we});
      chk("fwd_rd", {28'd0, fwd_rd}, {28'd0, q[0].rd});
      chk("fwd_data", {16'd0, fwd_data}, {16'd0, q[0].data});
`endif
      last_data = q[0].data;
      last_rd   = q[0].rd;
      last_ni   = q[0].ni;
    end else begin
      chk("idle_out_we", {31'd0, out_we}, 32'd0);
      chk("hold_wb_data", {16'd0, out_wb_data}, {16'd0, last_data});
      chk("hold_rd", {28'd0, out_rd}, {28'd0, last_rd});
      chk("hold_ni", {31'd0, out_ni}, {31'd0, last_ni});
`ifdef MEMORY_WRITEBACK_FORWARD_EN
      chk("idle_fwd_valid", {31'd0, fwd_valid}, 32'd0);
`endif
    end
    acc = in_valid && (q.size() < 2);
    rel = (q.size() > 0) && out_ready;
    if (flush) begin
      q.delete();
    end else begin
      if (rel) e = q.pop_front();
      if (acc) begin
        e.data = in_wbs ? in_mem_data : in_calc_data;
        e.rd   = in_rd;
        e.we   = in_we && (in_rd != '0);
        e.ni   = in_ni;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_data = '0;
    last_rd   = '0;
    last_ni   = 1'b0;
    rst       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);

    // Reset state
    #1 rst = 1'b1;
    #2 check_reset_outputs();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Single entry, memory data selected
    out_ready = 1'b1;
    drive(1'b1, 1'b1, 16'h1234, 16'hBEEF, 4'd3, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("single_out_wb_data", {16'd0, out_wb_data}, 32'h1234);
    chk("single_out_we", {31'd0, out_we}, 32'd1);
    cycle();
    cycle();

    // Backpressure: A and B fill the stage, C is held off
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0, 16'h0001, 4'd1, 1'b1, 1'b1);
    cycle();
    drive(1'b1, 1'b0, 16'h0, 16'h0002, 4'd2, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 1'b0, 16'h0, 16'h0003, 4'd5, 1'b0, 1'b1);
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    cycle();
    cycle();
    out_ready = 1'b1;
    cycle();
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    cycle();
    cycle();

    // Destination register 0 has its write enable dropped
    drive(1'b1, 1'b0, 16'h0, 16'h00FF, 4'd0, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b0;
    chk("rd0_out_valid", {31'd0, out_valid}, 32'd1);
    chk("rd0_out_we", {31'd0, out_we}, 32'd0);
    cycle();
    out_ready = 1'b1;
    cycle();
    cycle();

    // Flush while full with a new entry offered
    out_ready = 1'b0;
    drive(1'b1, 1'b1, 16'hD00D, 16'h0, 4'd7, 1'b1, 1'b1);
    cycle();
    drive(1'b1, 1'b1, 16'hE00E, 16'h0, 4'd8, 1'b1, 1'b0);
    cycle();
    drive(1'b1, 1'b1, 16'hF00F, 16'h0, 4'd9, 1'b1, 1'b1);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    cycle();
    cycle();

    // Asynchronous reset between edges while holding one entry
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0, 16'h5A5A, 4'd4, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    q.delete();
    last_data = '0;
    last_rd   = '0;
    last_ni   = 1'b0;
    #1 rst = 1'b0;

    // Streaming: one entry per cycle, full throughput
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 16'hFFFF, i[DW-1:0], i[AW-1:0] + 4'd1, 1'b1, i[0]);
      cycle();
    end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    cycle();
    cycle();

    // Mixed traffic with occasional flushes
    for (int unsigned i = 0; i < 60; i++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            DW'($urandom), DW'($urandom), AW'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      cycle();
    end
    flush = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    cycle();
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
